// File: rtl/fp_normalize_round_if.sv
// ---------------------------------------------------------------------------
// fp_normalize_round_if
//
// Purpose:
//   Bundles the upstream operand handshake and the downstream result
//   handshake of the normalise/round stage into one interface.
//
// Signals:
//   in_valid / in_ready   upstream bundle handshake
//   in_sign               sign of the raw sum
//   in_exp                biased exponent of the larger operand
//   in_mant               mantissa sum, hidden bit at the MSB
//   in_cout               carry-out of the mantissa adder
//   in_grs                guard/round/sticky, guard at [2]
//   out_valid / out_ready result handshake
//   result                packed IEEE single {sign, exp, frac}
//   overflow              result saturated to infinity
//   zero                  result is zero
//
// Modports:
//   master  drives the operand bundle and out_ready (upstream/testbench side)
//   slave   the normalise/round block itself
// ---------------------------------------------------------------------------
interface fp_normalize_round_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24
);

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic [EXP_W-1:0]        in_exp;
  logic [MANT_W-1:0]       in_mant;
  logic                    in_cout;
  logic [2:0]              in_grs;

  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+MANT_W-1:0] result;
  logic                    overflow;
  logic                    zero;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_cout, in_grs, out_ready,
    input  in_ready, out_valid, result, overflow, zero
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_cout, in_grs, out_ready,
    output in_ready, out_valid, result, overflow, zero
  );

endinterface

// File: rtl/fp_normalize_round.sv
// ---------------------------------------------------------------------------
// fp_normalize_round
//
// Purpose:
//   Output stage behind the single-precision mantissa adder/subtractor.
//   Normalises the raw sum (one right shift on carry-out, otherwise one
//   left shift per cycle), rounds to nearest-even and emits a packed
//   IEEE-754 single over a valid/ready handshake. One operation in flight.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous, active-high reset; aborts any operation in progress
//   bus  fp_normalize_round_if.slave carrying both handshakes, the operand
//        bundle and the result/flags
// ---------------------------------------------------------------------------
module fp_normalize_round #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_normalize_round_if.slave  bus
);

  localparam int               FRAC_W  = MANT_W - 1;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    OUT
  } state_t;

  state_t                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic [EXP_W-1:0]        exp_q, exp_d;
  logic [MANT_W-1:0]       mant_q, mant_d;
  logic                    g_q, g_d;
  logic                    r_q, r_d;
  logic                    s_q, s_d;
  logic [EXP_W+MANT_W-1:0] result_q, result_d;
  logic                    overflow_q, overflow_d;
  logic                    zero_q, zero_d;

  logic [EXP_W-1:0]        capExpInc;
  logic                    roundUp;
  logic [MANT_W:0]         mantSum;
  logic [MANT_W-1:0]       rndMant;
  logic [EXP_W-1:0]        rndExp;
  logic [EXP_W-1:0]        encExp;

  // Handshake outputs come straight from the state: we only take a bundle
  // while idle and only present a result while parked in OUT.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

  // Exponent after the carry-out right shift, needed at capture time to
  // spot the case where the carry alone pushes us to infinity.
  assign capExpInc = bus.in_exp + EXP_ONE;

  // Round-to-nearest-even datapath used in the ROUND state. A carry out of
  // the mantissa renormalises to 1.000... with the exponent bumped. When the
  // rounded mantissa has its hidden bit set the exponent field is at least 1,
  // which is what lets a subnormal that rounds up to 0x800000 become the
  // smallest normal. With no hidden bit the value is subnormal and encodes
  // exponent 0.
  always_comb begin
    roundUp = g_q & (r_q | s_q | mant_q[0]);
    mantSum = {1'b0, mant_q} + {{MANT_W{1'b0}}, roundUp};
    rndMant = mantSum[MANT_W-1:0];
    rndExp  = exp_q;
    encExp  = '0;
    if (mantSum[MANT_W]) begin
      rndMant = {1'b1, {FRAC_W{1'b0}}};
      rndExp  = exp_q + EXP_ONE;
    end
    if (rndMant[MANT_W-1]) begin
      encExp = (rndExp == '0) ? EXP_ONE : rndExp;
    end
  end

  // Next-state and datapath process. Everything holds by default; each
  // state only overrides what it actually changes. The early exits at
  // capture (special passthrough, exact zero, carry overflow) jump straight
  // to OUT so their result is ready one cycle after the accept edge.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mant_d     = mant_q;
    g_d        = g_q;
    r_d        = r_q;
    s_d        = s_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d     = bus.in_sign;
          overflow_d = 1'b0;
          zero_d     = 1'b0;
          if (bus.in_exp == EXP_MAX) begin
            result_d = {bus.in_sign, EXP_MAX, bus.in_mant[FRAC_W-1:0]};
            state_d  = OUT;
          end else if (!bus.in_cout && (bus.in_mant == '0)) begin
            result_d = '0;
            zero_d   = 1'b1;
            state_d  = OUT;
          end else if (bus.in_cout) begin
            mant_d = {1'b1, bus.in_mant[MANT_W-1:1]};
            g_d    = bus.in_mant[0];
            r_d    = bus.in_grs[2];
            s_d    = bus.in_grs[1] | bus.in_grs[0];
            exp_d  = capExpInc;
            if (capExpInc == EXP_MAX) begin
              result_d   = {bus.in_sign, EXP_MAX, {FRAC_W{1'b0}}};
              overflow_d = 1'b1;
              state_d    = OUT;
            end else begin
              state_d = NORM;
            end
          end else begin
            mant_d  = bus.in_mant;
            g_d     = bus.in_grs[2];
            r_d     = bus.in_grs[1];
            s_d     = bus.in_grs[0];
            exp_d   = bus.in_exp;
            state_d = NORM;
          end
        end
      end

      NORM: begin
        // Stop once the hidden bit is set, or once the exponent can go no
        // lower; in the latter case the value ends up subnormal.
        if (mant_q[MANT_W-1] || (exp_q <= EXP_ONE)) begin
          state_d = ROUND;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], g_q};
          g_d    = r_q;
          r_d    = 1'b0;
          exp_d  = exp_q - EXP_ONE;
        end
      end

      ROUND: begin
        if (encExp == EXP_MAX) begin
          result_d   = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
          overflow_d = 1'b1;
          zero_d     = 1'b0;
        end else begin
          result_d   = {sign_q, encExp, rndMant[FRAC_W-1:0]};
          overflow_d = 1'b0;
          zero_d     = (encExp == '0) && (rndMant[FRAC_W-1:0] == '0);
        end
        state_d = OUT;
      end

      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset returns to IDLE with cleared
  // result/flags and throws away whatever was being worked on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mant_q     <= '0;
      g_q        <= 1'b0;
      r_q        <= 1'b0;
      s_q        <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      mant_q     <= mant_d;
      g_q        <= g_d;
      r_q        <= r_d;
      s_q        <= s_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

endmodule
